// File: rtl/riscv_pipe_pkg.sv
// Shared types and encodings for the five-stage RV32 pipeline control blocks.
package riscv_pipe_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] RES_LOAD = 2'b01;

  typedef enum logic {
    HZ_IDLE,
    HZ_BUSY
  } hz_state_t;

endpackage

// File: rtl/ex_occupancy.sv
// Holds Execute for MC_LAT cycles while a multi-cycle op (mul/div) occupies it.
module ex_occupancy
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned MC_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic MultiCycleE,
  output logic ExBusy
);

  localparam bit                IS_MULTI = (MC_LAT > 1);
  localparam logic [CNT_W-1:0]  CNT_INIT = IS_MULTI ? CNT_W'(MC_LAT - 2) : '0;

  hz_state_t         state, stateNext;
  logic [CNT_W-1:0]  cnt, cntNext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= HZ_IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // The release cycle stays in BUSY so the still-present op cannot retrigger.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    ExBusy    = 1'b0;
    case (state)
      HZ_IDLE: begin
        if (enable && MultiCycleE && IS_MULTI) begin
          ExBusy    = 1'b1;
          stateNext = HZ_BUSY;
          cntNext   = CNT_INIT;
        end
      end
      HZ_BUSY: begin
        if (cnt != '0) begin
          ExBusy  = 1'b1;
          cntNext = cnt - CNT_W'(1);
        end else begin
          stateNext = HZ_IDLE;
        end
      end
      default: stateNext = HZ_IDLE;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and interlock controller for the five-stage RV32 pipeline.
module hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned REGW   = 5,
  parameter bit          FWD_EN = 1'b1,
  parameter int unsigned MC_LAT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] Rs1D,
  input  logic [REGW-1:0] Rs2D,
  input  logic [REGW-1:0] Rs1E,
  input  logic [REGW-1:0] Rs2E,
  input  logic [REGW-1:0] RdE,
  input  logic [REGW-1:0] RdM,
  input  logic [REGW-1:0] RdWB,
  input  logic            RegWriteE,
  input  logic            RegWriteM,
  input  logic            RegWriteWB,
  input  logic [1:0]      ResultSrcE,
  input  logic            PCSrcE,
  input  logic            MultiCycleE,
  output logic            StallF,
  output logic            StallD,
  output logic            StallE,
  output logic            FlushD,
  output logic            FlushE,
  output logic            FlushM,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic            ExBusy
);

  logic     resetQ;
  logic     rstFlush;
  logic     loadUse;
  logic     interlock;
  logic     hazard;
  logic     hazHold;
  logic     branch;
  fwd_sel_t fwdA, fwdB;

  // A nonzero source that a writing stage is about to produce.
  function automatic logic srcHit(input logic [REGW-1:0] rs,
                                  input logic [REGW-1:0] rd,
                                  input logic            we);
    return we && (rs != '0) && (rs == rd);
  endfunction

  function automatic fwd_sel_t fwdSel(input logic [REGW-1:0] rs,
                                      input logic [REGW-1:0] rdM,
                                      input logic            weM,
                                      input logic [REGW-1:0] rdWB,
                                      input logic            weWB);
    if (srcHit(rs, rdM, weM))        return FWD_MEM;
    else if (srcHit(rs, rdWB, weWB)) return FWD_WB;
    else                             return FWD_RF;
  endfunction

  // Keeps the reset flush alive for one clock after reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) resetQ <= 1'b0;
    else        resetQ <= 1'b1;
  end

  assign rstFlush = ~resetQ;

  ex_occupancy #(
    .MC_LAT (MC_LAT)
  ) u_occ (
    .clk         (clk),
    .reset       (reset),
    .enable      (resetQ),
    .MultiCycleE (MultiCycleE),
    .ExBusy      (ExBusy)
  );

  assign loadUse   = (ResultSrcE == RES_LOAD) && (RdE != '0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));
  assign interlock = srcHit(Rs1D, RdE, RegWriteE) || srcHit(Rs1D, RdM, RegWriteM) ||
                     srcHit(Rs2D, RdE, RegWriteE) || srcHit(Rs2D, RdM, RegWriteM);

  always_comb begin
    fwdA   = FWD_RF;
    fwdB   = FWD_RF;
    hazard = interlock;
    if (FWD_EN) begin
      fwdA   = fwdSel(Rs1E, RdM, RegWriteM, RdWB, RegWriteWB);
      fwdB   = fwdSel(Rs2E, RdM, RegWriteM, RdWB, RegWriteWB);
      hazard = loadUse;
    end
  end

  // A busy Execute owns the pipeline; a taken branch beats data-hazard stalls.
  assign branch  = PCSrcE && !ExBusy;
  assign hazHold = hazard && !PCSrcE && !ExBusy;

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    FlushM    = 1'b1;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (!rstFlush) begin
      StallF    = ExBusy || hazHold;
      StallD    = ExBusy || hazHold;
      StallE    = ExBusy;
      FlushD    = branch;
      FlushE    = branch || hazHold;
      FlushM    = ExBusy;
      ForwardAE = fwdA;
      ForwardBE = fwdB;
    end
  end

endmodule
